// File: rtl/in_fifo_pkg.sv
// in_fifo_pkg: shared widths, depths and FSM encoding for the IN_FIFO read-side drain stage
package in_fifo_pkg;
    localparam int LANES      = 10;
    localparam int LANE_W     = 8;
    localparam int WORD_W     = LANES * LANE_W;
    localparam int SKID_DEPTH = 2;
    localparam int CNT_W      = 16;
    typedef enum logic [1:0] {RUN, FLUSHING, DONE} state_e;
endpackage

// File: rtl/in_fifo_drain_if.sv
// in_fifo_drain_if: valid/ready word stream from the drain stage to the fabric consumer
interface in_fifo_drain_if;
    import in_fifo_pkg::*;
    logic              valid;
    logic              ready;
    logic [WORD_W-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/in_fifo_skid2.sv
// in_fifo_skid2: two-entry ordered buffer holding captured IN_FIFO words
module in_fifo_skid2
    import in_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WORD_W-1:0] din_i,
    output logic [WORD_W-1:0] dout_o,
    output logic [1:0]        occ_o
);
    logic [WORD_W-1:0] mem_q [SKID_DEPTH];
    logic [WORD_W-1:0] mem_d [SKID_DEPTH];
    logic              wp_q, wp_d, rp_q, rp_d;
    logic [1:0]        occ_q, occ_d;

    always_comb begin
        mem_d = mem_q;
        if (push_i) mem_d[wp_q] = din_i;
        wp_d  = clr_i ? 1'b0 : wp_q ^ push_i;
        rp_d  = clr_i ? 1'b0 : rp_q ^ pop_i;
        occ_d = clr_i ? 2'd0 : occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
        end
    end

    assign dout_o = mem_q[rp_q];
    assign occ_o  = occ_q;
endmodule

// File: rtl/in_fifo_drain.sv
// in_fifo_drain: issues IN_FIFO reads, skid-buffers the lanes into a valid/ready stream,
// and runs the flush sequence and delivered-word counter.
module in_fifo_drain
    import in_fifo_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_empty_i,
    input  logic               fifo_almostempty_i,
    input  logic [WORD_W-1:0]  fifo_q_i,
    output logic               fifo_rden_o,
    input  logic               flush_i,
    output logic               flush_done_o,
    output logic [CNT_W-1:0]   word_cnt_o,
    in_fifo_drain_if.master    m
);
    state_e           state_q, state_d;
    logic             inflight_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       occ;
    logic             push, pop, clr, rd_ok, room;

    assign push  = inflight_q;
    assign pop   = m.valid && m.ready;
    assign clr   = flush_i || state_q != RUN;
    // rst_n gates the read so RDEN is low for the whole reset, not just after the next edge
    assign rd_ok = rst_n && !fifo_empty_i && !(inflight_q && fifo_almostempty_i);
    assign room  = {1'b0, occ} + {2'b0, inflight_q} < 3'(SKID_DEPTH) + {2'b0, pop};
    assign cnt_d = pop ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d     = state_q;
        fifo_rden_o = 1'b0;
        unique case (state_q)
            RUN: begin
                fifo_rden_o = rd_ok && room;
                state_d     = flush_i ? FLUSHING : RUN;
            end
            FLUSHING: begin
                fifo_rden_o = rd_ok;
                state_d     = fifo_empty_i && !inflight_q ? DONE : FLUSHING;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rden_o;
            cnt_q      <= cnt_d;
        end
    end

    in_fifo_skid2 u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (fifo_q_i),
        .dout_o (m.data),
        .occ_o  (occ)
    );

    assign m.valid      = occ != 2'd0;
    assign flush_done_o = state_q == DONE;
    assign word_cnt_o   = cnt_q;
endmodule

// File: tb/tb_in_fifo_drain.sv
// tb_in_fifo_drain: IN_FIFO behavioural model plus scoreboard for the drain stage
module tb_in_fifo_drain;
    import in_fifo_pkg::*;
    typedef logic [WORD_W-1:0] w_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             fifo_rden, flush_done, fifo_empty, fifo_ae;
    logic [CNT_W-1:0] word_cnt;
    w_t               fifo_q = '0;
    w_t               fifo_mem[$];
    w_t               exp_q[$];
    int               wr_cnt = 0;
    int               rd_cnt = 0;
    int               n_chk = 0;
    int               n_pass = 0;
    logic             pv = 1'b0, pr = 1'b0, prd = 1'b0;
    w_t               pd = '0;

    in_fifo_drain_if m();

    in_fifo_drain dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fifo_empty_i       (fifo_empty),
        .fifo_almostempty_i (fifo_ae),
        .fifo_q_i           (fifo_q),
        .fifo_rden_o        (fifo_rden),
        .flush_i            (flush),
        .flush_done_o       (flush_done),
        .word_cnt_o         (word_cnt),
        .m                  (m)
    );

    always #5 clk = ~clk;

    assign fifo_empty = wr_cnt == rd_cnt;
    assign fifo_ae    = (wr_cnt - rd_cnt) <= 2;

    // IN_FIFO read port: Q shows the word one RDCLK after RDEN
    always @(posedge clk)
        if (fifo_rden && !fifo_empty) begin
            fifo_q <= fifo_mem.pop_front();
            rd_cnt <= rd_cnt + 1;
        end

    task automatic chk(input string tag, input w_t got, input w_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic w_t wd(input int k);
        logic [15:0] s;
        s  = k[15:0];
        wd = {LANES{s[7:0]}} ^ (w_t'(s[15:8]) << (WORD_W - 8));
    endfunction

    always @(negedge clk) begin
        chk("rd_empty", w_t'(fifo_rden & fifo_empty), '0);
        chk("rd_b2b", w_t'(fifo_rden & prd & fifo_ae), '0);
        chk("skid_ovf", w_t'(dut.push & (dut.occ == 2'd2) & ~dut.pop), '0);
        if (m.valid && pv && !pr) chk("hold", m.data, pd);
        if (m.valid && m.ready) begin
            if (exp_q.size() == 0) chk("extra_word", w_t'(exp_q.size()), w_t'(1));
            else chk("data", m.data, exp_q.pop_front());
        end
        pv  <= m.valid;
        pr  <= m.ready;
        pd  <= m.data;
        prd <= fifo_rden;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input int base, input bit keep);
        for (int i = 0; i < n; i++) begin
            fifo_mem.push_back(wd(base + i));
            if (keep) exp_q.push_back(wd(base + i));
        end
        wr_cnt = wr_cnt + n;
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while ((exp_q.size() != 0 || m.valid || wr_cnt != rd_cnt) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("drain_to", w_t'(i < budget), w_t'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_rden"}, w_t'(fifo_rden), '0);
        chk({tag, "_valid"}, w_t'(m.valid), '0);
        chk({tag, "_data"}, m.data, '0);
        chk({tag, "_done"}, w_t'(flush_done), '0);
        chk({tag, "_cnt"}, w_t'(word_cnt), '0);
    endtask

    task automatic areset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 rst_chk(tag);
        fifo_mem.delete();
        exp_q.delete();
        wr_cnt = rd_cnt;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        m.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_chk("por");
        rst_n = 1'b1;
        // streaming at full rate
        tick(); m.ready = 1'b1; load(8, 1, 1'b1);
        @(negedge clk) chk("st_rden", w_t'(fifo_rden), w_t'(1));
        drain(100);
        chk("st_cnt", w_t'(word_cnt), w_t'(8));
        // backpressure: only two reads fit the skid
        tick(); m.ready = 1'b0; load(8, 1, 1'b1);
        n = 0;
        repeat (10) begin @(negedge clk); n += int'(fifo_rden); end
        chk("bp_reads", w_t'(n), w_t'(2));
        chk("bp_valid", w_t'(m.valid), w_t'(1));
        chk("bp_head", m.data, wd(1));
        tick(); m.ready = 1'b1;
        drain(100);
        chk("bp_cnt", w_t'(word_cnt), w_t'(16));
        // near empty: reads must be spaced
        tick(); load(2, 9, 1'b1);
        n = 0;
        repeat (10) begin @(negedge clk); n += int'(fifo_rden); end
        chk("ne_reads", w_t'(n), w_t'(2));
        drain(50);
        chk("ne_cnt", w_t'(word_cnt), w_t'(18));
        // flush with one word buffered and five queued
        tick(); m.ready = 1'b0; load(1, 8'h11, 1'b1);
        repeat (4) @(negedge clk);
        chk("fl_pre_valid", w_t'(m.valid), w_t'(1));
        tick(); load(5, 8'h21, 1'b0); flush = 1'b1;
        tick(); flush = 1'b0; exp_q.delete();
        @(negedge clk) chk("fl_valid", w_t'(m.valid), '0);
        tick(); flush = 1'b1;
        tick(); flush = 1'b0;
        n = 0;
        repeat (30) begin @(negedge clk); n += int'(flush_done); end
        chk("fl_done", w_t'(n), w_t'(1));
        chk("fl_empty", w_t'(fifo_empty), w_t'(1));
        chk("fl_cnt", w_t'(word_cnt), w_t'(18));
        tick(); m.ready = 1'b1; load(1, 8'hAA, 1'b1);
        drain(50);
        chk("fl_after", w_t'(word_cnt), w_t'(19));
        // flush on an idle, empty FIFO
        tick(); flush = 1'b1;
        tick(); flush = 1'b0;
        @(negedge clk) chk("if_d1", w_t'(flush_done), '0);
        @(negedge clk) chk("if_d2", w_t'(flush_done), w_t'(1));
        @(negedge clk) chk("if_d3", w_t'(flush_done), '0);
        // reset in the middle of a flush
        tick(); m.ready = 1'b0; load(6, 8'h41, 1'b0); flush = 1'b1;
        tick(); flush = 1'b0;
        areset("rf");
        n = 0;
        repeat (8) begin @(negedge clk); n += int'(flush_done); end
        chk("rf_nodone", w_t'(n), '0);
        // reset in the middle of a stream
        tick(); m.ready = 1'b1; load(8, 8'h31, 1'b1);
        repeat (4) @(negedge clk);
        areset("rs");
        @(negedge clk) chk("rs_valid", w_t'(m.valid), '0);
        tick(); load(1, 8'h77, 1'b1);
        drain(50);
        chk("rs_cnt", w_t'(word_cnt), w_t'(1));
        // counter wrap
        tick(); load(16'hFFFD, 16'h100, 1'b1);
        drain(70000);
        chk("wr_fffe", w_t'(word_cnt), w_t'(16'hFFFE));
        tick(); load(3, 8'hE0, 1'b1);
        drain(50);
        chk("wr_wrap", w_t'(word_cnt), w_t'(1));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/in_fifo_drain.md
Name: in_fifo_drain

Overview:
- Read-side drain stage directly downstream of the IN_FIFO primitive, running in its RDCLK domain.
- Generates RDEN from EMPTY/ALMOSTEMPTY and captures the registered Q0..Q9 lanes into a 2-entry skid buffer.
- Presents captured words as a valid/ready stream to the fabric consumer.
- Provides a FLUSH sequence that discards all FIFO contents and a 16-bit delivered-word counter.

Parameters:
- LANES, 10, number of 8-bit Q lanes concatenated into one word (lane 0 in LSBs).
- LANE_W, 8, bits per lane (4 for ARRAY_MODE_4_X_4 usage, upper bits ignored by consumer).
- SKID_DEPTH, 2, output buffer entries; fixed at read latency + 1.

Ports:
- RDCLK  in  1  sole clock, same net as the IN_FIFO RDCLK.
- RESETB  in  1  asynchronous, active-low reset.
- FIFO_EMPTY  in  1  IN_FIFO EMPTY.
- FIFO_ALMOSTEMPTY  in  1  IN_FIFO ALMOSTEMPTY.
- FIFO_Q  in  LANES*LANE_W  {Q9..Q0} from IN_FIFO.
- FIFO_RDEN  out  1  IN_FIFO RDEN.
- FLUSH  in  1  single-cycle request to discard all data.
- FLUSH_DONE  out  1  single-cycle pulse when flush completes.
- M_VALID  out  1  output word valid.
- M_READY  in  1  consumer accepts the word.
- M_DATA  out  LANES*LANE_W  output word.
- WORD_CNT  out  16  count of words delivered (M_VALID && M_READY).

Behaviour:
- Reset (RESETB low, async): FIFO_RDEN=0, M_VALID=0, M_DATA=0, FLUSH_DONE=0, WORD_CNT=0, buffer empty, inflight=0, state=RUN.
- Read latency: FIFO_Q holds the word read by FIFO_RDEN exactly one RDCLK later. inflight is FIFO_RDEN registered; when inflight=1, FIFO_Q is captured that cycle.
- RDEN rule: assert only when all of the following hold:
  - FIFO_EMPTY=0;
  - NOT (inflight=1 AND FIFO_ALMOSTEMPTY=1), i.e. no back-to-back reads near empty;
  - in RUN: occupancy + inflight − pop < SKID_DEPTH, where pop = M_VALID && M_READY.
  - FIFO_RDEN is combinational from registered state plus FIFO flags and M_READY.
- Skid buffer: 2-entry FIFO with ordered pointers.
  - M_DATA = head entry; M_VALID = occupancy != 0.
  - Simultaneous push and pop at occupancy 2 is legal; occupancy stays 2.
  - Push at occupancy 2 without pop cannot occur by construction; the bench asserts this.
  - M_DATA stays stable while M_VALID=1 and M_READY=0.
- WORD_CNT: +1 per pop; wraps from 0xFFFF to 0x0000; not cleared by FLUSH.
- State machine:
  - RUN: normal operation. FLUSH=1 → FLUSHING; the buffer is cleared that edge and M_VALID drops the next cycle, even mid-handshake.
  - FLUSHING: M_VALID=0. RDEN follows the empty and no-back-to-back rules only, with no occupancy limit. Captured words are discarded. When FIFO_EMPTY=1 and inflight=0 → DONE.
  - DONE: FLUSH_DONE=1 for one cycle, FIFO_RDEN=0, then → RUN.
  - FLUSH in FLUSHING or DONE is ignored.
- FLUSH on an idle, empty FIFO: FLUSHING lasts 1 cycle, then DONE, so FLUSH_DONE pulses 2 cycles after FLUSH.
- Reset mid-flush: returns to RUN with no FLUSH_DONE.

Decomposition:
- Shared package in_fifo_pkg holds:
  - the state enum {RUN, FLUSHING, DONE};
  - localparam WORD_W = LANES*LANE_W;
  - the 16-bit count width.
- One sub-module: in_fifo_skid2, the 2-entry push/pop buffer with occupancy output.
- RDEN logic, the FSM and the counter stay in the top module.

Test Plan:
- Streaming: FIFO preloaded with 8 words 0x01..0x08 (all lanes), M_READY=1 → RDEN asserts from cycle 1; M_DATA 0x01..0x08 in order, one per cycle once ALMOSTEMPTY=0; WORD_CNT=8.
- Backpressure: 8 words, M_READY=0 for 10 cycles → exactly 2 reads issued, then RDEN=0. M_DATA holds word 0x01. On M_READY=1, all 8 words arrive in order with no loss or duplicate.
- Near-empty: ALMOSTEMPTY=1 with 2 words → RDEN never high on consecutive cycles; no RDEN while EMPTY=1.
- Flush: 5 words queued, 1 in buffer, pulse FLUSH → M_VALID=0 next cycle; FIFO drained to EMPTY; one FLUSH_DONE pulse; WORD_CNT unchanged; a subsequent word 0xAA is delivered normally.
- Wrap: WORD_CNT forced to 0xFFFE, deliver 3 words → WORD_CNT = 0x0001.
- Async reset: assert RESETB low mid-stream, between clock edges → all outputs reach their reset values immediately; after release, RUN resumes with an empty buffer.
